// File: rtl/stim_pkg.sv
// stim_pkg -- shared constants and types for the stimulus player.
//   WORD_W      : width of a stimulus word (one bit per digital pin)
//   DEF_DEPTH   : default FIFO depth in words
//   DEF_HOLD_W  : default width of the hold-count input
//   state_e     : playback FSM states
package stim_pkg;

    localparam int WORD_W     = 12;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_HOLD_W = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_e;

endpackage

// File: rtl/stim_fifo.sv
// stim_fifo -- word FIFO feeding the stimulus player.
//   clk, rst_n : clock, asynchronous active-low reset (pointers only)
//   flush_i    : synchronous empty, overrides push/pop
//   push_i     : write wdata_i at tail; accepted when not full, or when a pop
//                frees a slot in the same cycle (loop re-push of a full FIFO)
//   pop_i      : advance head; ignored when empty
//   rdata_o    : current head word (valid when !empty_o)
//   full_o     : FIFO holds DEPTH words
//   empty_o    : FIFO holds no words
// Pointers carry one extra wrap bit so full and empty differ only in the MSB.
module stim_fifo
    import stim_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int W     = WORD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, rptr_q;
    logic         do_push, do_pop;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PTR_ONE;
            if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
        end
    end

    // Storage needs no reset: contents are only visible through valid pointers.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/stim_player.sv
// stim_player -- queues 12-bit stimulus words and plays them onto the digital
// pins, holding each word for max(hold_cycles,1) clock cycles.
//   clk, rst_n    : clock, asynchronous active-low reset
//   in_valid/in_ready/in_data : word push handshake
//   hold_cycles   : per-word hold count, sampled whenever a word is loaded
//   start         : one-cycle playback request (IDLE, FIFO non-empty only)
//   abort         : flush FIFO, clear digital, return to IDLE (highest priority)
//   loop          : (STIM_PLAYER_LOOP_EN only) re-push each popped word
//   digital       : pin drive register
//   busy          : registered, high while in PLAY
//   done          : one-cycle pulse on normal completion
// Optional feature macro: STIM_PLAYER_LOOP_EN.
module stim_player
    import stim_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int HOLD_W = DEF_HOLD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic [HOLD_W-1:0] hold_cycles,
    input  logic              start,
    input  logic              abort,
`ifdef STIM_PLAYER_LOOP_EN
    input  logic              loop,
`endif
    output logic [WORD_W-1:0] digital,
    output logic              busy,
    output logic              done
);

    localparam logic [HOLD_W-1:0] HOLD_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   digital_q, digital_d;
    logic [HOLD_W-1:0]   hold_q, hold_d, hold_load;
    logic                busy_q, done_q, done_d;
    logic                pop, repush, ext_push;
    logic                fifo_full, fifo_empty;
    logic [WORD_W-1:0]   fifo_rdata;

    // hold_q counts the cycles remaining for the current word, including this one.
    assign hold_load = (hold_cycles == '0) ? HOLD_ONE : hold_cycles;

    always_comb begin
        state_d   = state_q;
        digital_d = digital_q;
        hold_d    = hold_q;
        done_d    = 1'b0;
        pop       = 1'b0;
        if (abort) begin
            state_d   = ST_IDLE;
            digital_d = '0;
            hold_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !fifo_empty) begin
                        pop       = 1'b1;
                        digital_d = fifo_rdata;
                        hold_d    = hold_load;
                        state_d   = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (hold_q <= HOLD_ONE) begin
                        // Empty is the registered flag, so a push landing in
                        // this same cycle stays queued instead of extending play.
                        if (!fifo_empty) begin
                            pop       = 1'b1;
                            digital_d = fifo_rdata;
                            hold_d    = hold_load;
                        end else begin
                            state_d = ST_IDLE;
                            hold_d  = '0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        hold_d = hold_q - HOLD_ONE;
                    end
                end
            endcase
        end
    end

`ifdef STIM_PLAYER_LOOP_EN
    assign repush = pop && loop;
`else
    assign repush = 1'b0;
`endif

    // A loop re-push owns the write port, so the external side is stalled.
    assign in_ready = !fifo_full && !repush;
    assign ext_push = in_valid && in_ready && !abort;

    stim_fifo #(
        .DEPTH (DEPTH),
        .W     (WORD_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (abort),
        .push_i  (ext_push || repush),
        .wdata_i (repush ? fifo_rdata : in_data),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            digital_q <= '0;
            hold_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            digital_q <= digital_d;
            hold_q    <= hold_d;
            busy_q    <= (state_d == ST_PLAY);
            done_q    <= done_d;
        end
    end

    assign digital = digital_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_stim_player.sv
// tb_stim_player -- directed self-checking bench for stim_player.
// Inputs are driven and outputs sampled on the falling clock edge.
// Define STIM_PLAYER_LOOP_EN to also exercise the loop port.
module tb_stim_player;
    import stim_pkg::*;

    localparam int DEPTH  = 16;
    localparam int HOLD_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              in_ready, busy, done;
    logic [WORD_W-1:0] in_data = '0;
    logic [WORD_W-1:0] digital;
    logic [HOLD_W-1:0] hold_cycles = '0;
`ifdef STIM_PLAYER_LOOP_EN
    logic              loop = 1'b0;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    stim_player #(
        .DEPTH  (DEPTH),
        .HOLD_W (HOLD_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .hold_cycles (hold_cycles),
        .start       (start),
        .abort       (abort),
`ifdef STIM_PLAYER_LOOP_EN
        .loop        (loop),
`endif
        .digital     (digital),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic push(input logic [WORD_W-1:0] w);
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic kick(input logic [HOLD_W-1:0] h);
        hold_cycles = h;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [WORD_W-1:0] w);
        check({tag, "_digital"}, 32'(digital), 32'(w));
        check({tag, "_busy"},    32'(busy),    32'd1);
        check({tag, "_done"},    32'(done),    32'd0);
        @(negedge clk);
    endtask

    initial begin
        // reset
        repeat (2) @(negedge clk);
        check("rst_digital", 32'(digital), 32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_done",    32'(done),    32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // three words, hold 3
        push(12'h001); push(12'h002); push(12'h003);
        kick(16'd3);
        for (int i = 0; i < 9; i++) expect_word("basic", 12'(i / 3 + 1));
        check("basic_done",     32'(done),    32'd1);
        check("basic_busy_end", 32'(busy),    32'd0);
        check("basic_last",     32'(digital), 32'h003);
        @(negedge clk);
        check("basic_done_1cyc", 32'(done),    32'd0);
        check("basic_hold_last", 32'(digital), 32'h003);

        // push on the expiry cycle of an empty FIFO stays queued
        push(12'h0AB);
        kick(16'd2);
        expect_word("late_a", 12'h0AB);
        check("late_a_last", 32'(digital), 32'h0AB);
        in_valid = 1'b1;
        in_data  = 12'h0CD;
        @(negedge clk);
        in_valid = 1'b0;
        check("late_done",    32'(done),    32'd1);
        check("late_busy",    32'(busy),    32'd0);
        check("late_digital", 32'(digital), 32'h0AB);
        kick(16'd1);
        expect_word("late_b", 12'h0CD);
        check("late_b_done", 32'(done), 32'd1);
        @(negedge clk);

        // fill to DEPTH, overflow attempt, first pop frees a slot
        for (int i = 0; i < 16; i++) push(12'(32'h100 + i));
        check("full_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data  = 12'hFFF;
        @(negedge clk);
        in_valid = 1'b0;
        check("full_ready_hold", 32'(in_ready), 32'd0);
        kick(16'd1);
        check("full_ready_after_pop", 32'(in_ready), 32'd1);
        for (int i = 0; i < 16; i++) expect_word("full", 12'(32'h100 + i));
        check("full_done", 32'(done), 32'd1);
        check("full_busy", 32'(busy), 32'd0);
        @(negedge clk);

        // start with FIFO empty is ignored
        kick(16'd1);
        check("empty_busy", 32'(busy), 32'd0);
        check("empty_done", 32'(done), 32'd0);
        @(negedge clk);
        check("empty_busy2",   32'(busy),    32'd0);
        check("empty_done2",   32'(done),    32'd0);
        check("empty_digital", 32'(digital), 32'h10F);

        // hold_cycles = 0 acts as 1
        push(12'h011); push(12'h022);
        kick(16'd0);
        expect_word("hold0_a", 12'h011);
        expect_word("hold0_b", 12'h022);
        check("hold0_done", 32'(done), 32'd1);
        check("hold0_busy", 32'(busy), 32'd0);
        @(negedge clk);

        // abort during second word
        push(12'h0A1); push(12'h0A2); push(12'h0A3); push(12'h0A4);
        kick(16'd3);
        for (int i = 0; i < 3; i++) expect_word("abort_w1", 12'h0A1);
        check("abort_w2", 32'(digital), 32'h0A2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_digital", 32'(digital),  32'd0);
        check("abort_busy",    32'(busy),     32'd0);
        check("abort_done",    32'(done),     32'd0);
        check("abort_ready",   32'(in_ready), 32'd1);
        @(negedge clk);
        check("abort_done2", 32'(done), 32'd0);
        kick(16'd1);
        check("abort_flushed", 32'(busy), 32'd0);

        // asynchronous reset mid-play discards the queue
        push(12'h0E1); push(12'h0E2);
        kick(16'd5);
        expect_word("rstmid", 12'h0E1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_digital", 32'(digital), 32'd0);
        check("rstmid_busy",    32'(busy),    32'd0);
        check("rstmid_done",    32'(done),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        kick(16'd1);
        check("rstmid_flushed", 32'(busy),    32'd0);
        check("rstmid_dig0",    32'(digital), 32'd0);

`ifdef STIM_PLAYER_LOOP_EN
        // loop playback repeats until abort
        loop = 1'b1;
        push(12'hAAA); push(12'h555);
        kick(16'd2);
        for (int i = 0; i < 24; i++)
            expect_word("loop", ((i / 2) % 2 == 0) ? 12'hAAA : 12'h555);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        loop  = 1'b0;
        check("loop_abort_digital", 32'(digital), 32'd0);
        check("loop_abort_busy",    32'(busy),    32'd0);
        check("loop_abort_done",    32'(done),    32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/stim_player.md
STIM_PLAYER -- requirements
Module: stim_player

Interface
REQ-001 Parameter DEPTH, default 16, is the FIFO depth in words; it SHALL be a power of two, minimum 2.
REQ-002 Parameter HOLD_W, default 16, is the width of the hold-count input.
REQ-003 Port clk  input  1  is the single clock; all state SHALL be on its rising edge.
REQ-004 Port rst_n  input  1  is the reset; it SHALL be asynchronous and active-low.
REQ-005 Port in_valid  input  1  indicates in_data is valid for a push.
REQ-006 Port in_ready  output  1  indicates the FIFO can accept a word.
REQ-007 Port in_data  input  12  is the stimulus word; bit n drives digitaln.
REQ-008 Port hold_cycles  input  HOLD_W  is the cycles each word is held, sampled at each word load.
REQ-009 Port start  input  1  is a one-cycle playback request.
REQ-010 Port abort  input  1  stops playback and flushes the FIFO.
REQ-011 Port digital  output  12  drives digital0..digital11 of the pin-out stage.
REQ-012 Port busy  output  1  is high while in PLAY.
REQ-013 Port done  output  1  is a one-cycle pulse on normal playback completion.

Function
REQ-014 A push SHALL occur when in_valid && in_ready; in_ready SHALL equal !full, independent of same-cycle pops.
REQ-015 The FSM SHALL have states IDLE and PLAY.
REQ-016 In IDLE, start with FIFO non-empty SHALL pop the head word to digital on the next edge, load the hold counter and enter PLAY.
REQ-017 In IDLE, start with FIFO empty SHALL be ignored; no done pulse.
REQ-018 In PLAY, start SHALL be ignored.
REQ-019 The hold counter SHALL load max(hold_cycles,1); each word SHALL be driven for exactly that many cycles.
REQ-020 At hold expiry with FIFO non-empty, the next word SHALL appear on digital on the following edge with no gap cycle.
REQ-021 At hold expiry with FIFO empty, the FSM SHALL return to IDLE, pulse done for one cycle and keep digital at the last word.
REQ-022 A push in the same cycle as hold expiry on an empty FIFO SHALL NOT extend playback; the word stays queued.
REQ-023 abort SHALL take priority over start, push and pop: next edge empties the FIFO, clears digital to 0, enters IDLE, no done pulse.
REQ-024 Read and write pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full/empty SHALL derive from the MSB comparison.
REQ-025 busy SHALL be a registered output equal to (state==PLAY).

Reset
REQ-026 On rst_n low: FIFO empty, state IDLE, digital=0, busy=0, done=0, hold counter 0; in_ready SHALL be 1 from the first edge after release.
REQ-027 Reset asserted mid-playback SHALL discard all queued words immediately.

Configuration
REQ-028 Macro STIM_PLAYER_LOOP_EN SHALL, when defined, add input loop; with loop=1, each popped word SHALL be re-pushed at the tail, so playback repeats until abort.
REQ-029 With STIM_PLAYER_LOOP_EN defined, a re-push SHALL take precedence over an external push; in_ready SHALL be 0 in that cycle.
REQ-030 Without STIM_PLAYER_LOOP_EN, no loop port SHALL exist and behaviour SHALL be REQ-014..REQ-025 only.

Structure
REQ-031 Package stim_pkg SHALL hold the word width constant (12), the default DEPTH and HOLD_W, and the FSM state enum.
REQ-032 Sub-module stim_fifo SHALL implement the storage and pointers; stim_player SHALL contain the FSM, hold counter and output register.

Verification
REQ-033 Push 0x001, 0x002, 0x003; hold_cycles=3; start -> digital = 0x001, 0x002, 0x003 for 3 cycles each; done pulses once; digital stays 0x003.
REQ-034 Push 16 words with DEPTH=16 -> in_ready=0; a 17th in_valid is not accepted; after start and the first pop, in_ready=1 the next cycle.
REQ-035 Set hold_cycles=0 with 2 words queued; start -> each word held 1 cycle; done after cycle 2.
REQ-036 Assert abort during the second word of 4 queued words -> digital=0, busy=0, FIFO empty, no done pulse.
REQ-037 Assert start with the FIFO empty -> busy stays 0 and no done pulse; assert rst_n low mid-PLAY -> all outputs return to reset values asynchronously.
REQ-038 With STIM_PLAYER_LOOP_EN and loop=1, queue 0xAAA and 0x555 with hold_cycles=2 -> alternating pattern persists for more than 20 cycles until abort.
